// File: rtl/calc_top_nbit.sv
// calc_top_nbit: WIDTH-bit board calculator. Conditions three raw buttons, holds operand
// registers, and runs add/sub in one cycle or a shift-add multiply over WIDTH cycles.
module calc_top_nbit #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   inA,
    input  logic [WIDTH-1:0]   inB,
    input  logic               btnLoadA,
    input  logic               btnLoadB,
    input  logic               btnExec,
    input  logic [1:0]         op,
    output logic [2*WIDTH-1:0] led_out,
    output logic               carry_borrow,
    output logic               busy,
    output logic               valid,
    output logic               err
);
    localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned IterW  = $clog2(WIDTH);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IterW-1:0] IterLast = IterW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    // ---------------- Button conditioning ----------------
    logic [2:0] btn_raw;
    logic [2:0] btn_pulse;
    assign btn_raw = {btnExec, btnLoadB, btnLoadA};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic           sync1_q, sync2_q, level_q, pulse_q;
        logic [DbW-1:0] cnt_q;

        // Synchronise, flip the level after DEBOUNCE_CYCLES differing samples, pulse on 0->1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= btn_raw[i];
                sync2_q <= sync1_q;
                pulse_q <= 1'b0;
                if (sync2_q != level_q) begin
                    if (cnt_q == DbLast) begin
                        level_q <= sync2_q;
                        pulse_q <= sync2_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        assign btn_pulse[i] = pulse_q;
    end

    logic load_a, load_b, load_any, exec_go;
    assign load_a   = btn_pulse[0];
    assign load_b   = btn_pulse[1];
    assign load_any = load_a | load_b;
    // An exec coinciding with a load is dropped so the result never mixes old and new operands
    assign exec_go  = btn_pulse[2] & ~load_any;

    // ---------------- Control FSM ----------------
    state_e state_q, state_d;
    logic [IterW-1:0] iter_q, iter_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (exec_go) state_d = (op == 2'b10) ? StMul : StDone;
            StMul:          if (iter_q == IterLast) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == StMul);
    end

    // ---------------- Datapath ----------------
    logic [WIDTH-1:0]   reg_a_q, reg_a_d, reg_b_q, reg_b_d, mplr_q, mplr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcnd_q, mcnd_d, led_q, led_d, acc_step;
    logic               cb_q, cb_d, valid_q, valid_d, err_q, err_d;
    logic [WIDTH:0]     add_sum;

    assign add_sum  = {1'b0, reg_a_q} + {1'b0, reg_b_q};
    assign acc_step = mplr_q[0] ? (acc_q + mcnd_q) : acc_q;

    // Operand loads, op dispatch and one shift-add iteration per MUL cycle
    always_comb begin
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        acc_d   = acc_q;
        mcnd_d  = mcnd_q;
        mplr_d  = mplr_q;
        iter_d  = iter_q;
        led_d   = led_q;
        cb_d    = cb_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (state_q == StMul) begin
            // Loads and execs arriving here are ignored
            acc_d  = acc_step;
            mcnd_d = mcnd_q << 1;
            mplr_d = mplr_q >> 1;
            iter_d = iter_q + 1'b1;
            if (iter_q == IterLast) begin
                led_d   = acc_step;
                cb_d    = 1'b0;
                valid_d = 1'b1;
            end
        end else begin
            if (load_a) reg_a_d = inA;
            if (load_b) reg_b_d = inB;
            if (load_any) begin
                valid_d = 1'b0;
                err_d   = 1'b0;
            end else if (exec_go) begin
                valid_d = 1'b1;
                err_d   = 1'b0;
                case (op)
                    2'b00: begin
                        led_d = {{(WIDTH-1){1'b0}}, add_sum};
                        cb_d  = add_sum[WIDTH];
                    end
                    2'b01: begin
                        led_d = {{WIDTH{1'b0}}, reg_a_q - reg_b_q};
                        cb_d  = (reg_a_q < reg_b_q);
                    end
                    2'b10: begin
                        // Old result stays on the LEDs but is no longer valid while busy
                        valid_d = 1'b0;
                        acc_d   = '0;
                        mcnd_d  = {{WIDTH{1'b0}}, reg_a_q};
                        mplr_d  = reg_b_q;
                        iter_d  = '0;
                    end
                    default: begin
                        led_d = '0;
                        cb_d  = 1'b0;
                        err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a_q <= '0;
            reg_b_q <= '0;
            acc_q   <= '0;
            mcnd_q  <= '0;
            mplr_q  <= '0;
            iter_q  <= '0;
            led_q   <= '0;
            cb_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            acc_q   <= acc_d;
            mcnd_q  <= mcnd_d;
            mplr_q  <= mplr_d;
            iter_q  <= iter_d;
            led_q   <= led_d;
            cb_q    <= cb_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign led_out      = led_q;
    assign carry_borrow = cb_q;
    assign valid        = valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_calc_top_nbit.sv
// Self-checking bench for calc_top_nbit with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_calc_top_nbit;
    localparam int unsigned W    = 4;
    localparam int unsigned D    = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   inA, inB;
    logic           btnLoadA, btnLoadB, btnExec;
    logic [1:0]     op;
    logic [2*W-1:0] led_out;
    logic           carry_borrow, busy, valid, err;
    logic [2*W+3:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned m_a, m_b, m_led;
    logic        m_cb, m_valid, m_err, m_busy;

    always #5 clk = ~clk;

    calc_top_nbit #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .inA          (inA),
        .inB          (inB),
        .btnLoadA     (btnLoadA),
        .btnLoadB     (btnLoadB),
        .btnExec      (btnExec),
        .op           (op),
        .led_out      (led_out),
        .carry_borrow (carry_borrow),
        .busy         (busy),
        .valid        (valid),
        .err          (err)
    );

    assign obs = {led_out, carry_borrow, valid, err, busy};

    function automatic logic [2*W+3:0] m_outs();
        logic [31:0] l = m_led;
        return {l[2*W-1:0], m_cb, m_valid, m_err, m_busy};
    endfunction

    // Completed exec result from plain arithmetic
    function automatic void model_exec(input int unsigned o);
        case (o)
            0: begin m_led = m_a + m_b; m_cb = ((m_a + m_b) > MASK); end
            1: begin m_led = (m_a - m_b) & MASK; m_cb = (m_a < m_b); end
            2: begin m_led = m_a * m_b; m_cb = 1'b0; end
            default: begin m_led = 0; m_cb = 1'b0; end
        endcase
        m_err   = (o == 3);
        m_valid = 1'b1;
        m_busy  = 1'b0;
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic load_a(input logic [W-1:0] v);
        inA = v; btnLoadA = 1'b1; step(D + 6);
        btnLoadA = 1'b0; step(D + 6);
        m_a = v; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic load_b(input logic [W-1:0] v);
        inB = v; btnLoadB = 1'b1; step(D + 6);
        btnLoadB = 1'b0; step(D + 6);
        m_b = v; m_valid = 1'b0; m_err = 1'b0;
    endtask

    // Leaves the bench in the cycle where the exec pulse is high
    task automatic start_exec(input logic [1:0] o);
        op = o; btnExec = 1'b1; step(2 + D);
    endtask

    task automatic finish_exec();
        btnExec = 1'b0; step(D + 6);
    endtask

    task automatic test_reset();
        rst = 1'b1; inA = '0; inB = '0; op = '0;
        btnLoadA = 1'b0; btnLoadB = 1'b0; btnExec = 1'b0;
        m_a = 0; m_b = 0; m_led = 0; m_cb = 0; m_valid = 0; m_err = 0; m_busy = 0;
        step(2);
        checks++;
        if (obs !== 12'h000) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", obs, 12'h000);
        end
        rst = 1'b0; step(2);
    endtask

    task automatic test_add();
        load_a(4'd9); load_b(4'd8);
        start_exec(2'b00);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL add_before_latency: got %h want %h", obs, m_outs());
        end
        step(1);
        model_exec(0);
        checks++;
        if (obs !== {8'h11, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL add_9_8: got %h want %h", obs, {8'h11, 4'b1100});
        end
        finish_exec();
    endtask

    task automatic test_sub();
        load_a(4'd3); load_b(4'd5);
        start_exec(2'b01); step(1); model_exec(1);
        checks++;
        if (obs !== {8'h0E, 4'b1100}) begin
            errors++; $display("FAIL sub_3_5: got %h want %h", obs, {8'h0E, 4'b1100});
        end
        finish_exec();
        load_a(4'd5); load_b(4'd3);
        start_exec(2'b01); step(1); model_exec(1);
        checks++;
        if (obs !== {8'h02, 4'b0100}) begin
            errors++; $display("FAIL sub_5_3: got %h want %h", obs, {8'h02, 4'b0100});
        end
        finish_exec();
    endtask

    task automatic test_mul();
        load_a(4'd15); load_b(4'd15);
        op = 2'b10; btnExec = 1'b1; step(2);
        // These presses mature while the multiply is running and must be discarded
        inA = 4'd3; inB = 4'd7; btnLoadA = 1'b1; btnLoadB = 1'b1;
        step(D); step(1);
        m_busy = 1'b1; m_valid = 1'b0; m_err = 1'b0;
        for (int k = 0; k < W; k++) begin
            checks++;
            if (obs !== m_outs()) begin
                errors++; $display("FAIL mul_busy_cycle%0d: got %h want %h", k, obs, m_outs());
            end
            op = 2'(k);
            step(1);
        end
        model_exec(2);
        checks++;
        if (obs !== {8'hE1, 4'b0100}) begin
            errors++; $display("FAIL mul_15_15: got %h want %h", obs, {8'hE1, 4'b0100});
        end
        btnExec = 1'b0; btnLoadA = 1'b0; btnLoadB = 1'b0; step(D + 6);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL mul_loads_discarded: got %h want %h", obs, m_outs());
        end
        start_exec(2'b00); step(1); model_exec(0);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL mul_regs_kept: got %h want %h", obs, m_outs());
        end
        finish_exec();
    endtask

    task automatic test_glitch_and_hold();
        inA = 4'd2; btnLoadA = 1'b1; step(2); btnLoadA = 1'b0; step(D + 6);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL glitch_no_load: got %h want %h", obs, m_outs());
        end
        inA = 4'd6; btnLoadA = 1'b1; step(2 + D);
        checks++;
        if (valid !== 1'b1) begin
            errors++; $display("FAIL load_latency: got valid=%b want 1", valid);
        end
        step(1);
        m_a = 6; m_valid = 1'b0; m_err = 1'b0;
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL load_clears_valid: got %h want %h", obs, m_outs());
        end
        // A second pulse from the held button would pick this value up
        inA = 4'd1; step(100 - 3 - D);
        btnLoadA = 1'b0; step(D + 6);
        start_exec(2'b00); step(1); model_exec(0);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL held_single_load: got %h want %h", obs, m_outs());
        end
        finish_exec();
    endtask

    task automatic test_reserved();
        start_exec(2'b11); step(1); model_exec(3);
        checks++;
        if (obs !== {8'h00, 4'b0110}) begin
            errors++; $display("FAIL reserved_op: got %h want %h", obs, {8'h00, 4'b0110});
        end
        finish_exec();
        load_b(4'd9);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL load_clears_err: got %h want %h", obs, m_outs());
        end
    endtask

    task automatic test_simultaneous();
        inA = 4'd12; inB = 4'd10; op = 2'b00;
        btnLoadA = 1'b1; btnLoadB = 1'b1; btnExec = 1'b1;
        step(3 + D);
        m_a = 12; m_b = 10; m_valid = 1'b0; m_err = 1'b0;
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL both_loads_exec_dropped: got %h want %h", obs, m_outs());
        end
        btnLoadA = 1'b0; btnLoadB = 1'b0; btnExec = 1'b0; step(D + 6);
        start_exec(2'b01); step(1); model_exec(1);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL both_loads_applied: got %h want %h", obs, m_outs());
        end
        finish_exec();
    endtask

    task automatic test_reset_mid_mul();
        load_a(4'd13); load_b(4'd11);
        start_exec(2'b10); step(2);
        m_busy = 1'b1; m_valid = 1'b0; m_err = 1'b0;
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL mul_second_cycle: got %h want %h", obs, m_outs());
        end
        #2 rst = 1'b1;
        #1;
        m_a = 0; m_b = 0; m_led = 0; m_cb = 0; m_valid = 0; m_err = 0; m_busy = 0;
        checks++;
        if (obs !== 12'h000) begin
            errors++; $display("FAIL async_reset_mid_mul: got %h want %h", obs, 12'h000);
        end
        btnExec = 1'b0; step(2); rst = 1'b0; step(W + 2);
        checks++;
        if (obs !== 12'h000) begin
            errors++; $display("FAIL no_result_after_abort: got %h want %h", obs, 12'h000);
        end
        load_a(4'd7); load_b(4'd14);
        start_exec(2'b00); step(1); model_exec(0);
        checks++;
        if (obs !== m_outs()) begin
            errors++; $display("FAIL add_after_reset: got %h want %h", obs, m_outs());
        end
        finish_exec();
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] a = W'($urandom_range(0, MASK));
            logic [W-1:0] b = W'($urandom_range(0, MASK));
            logic [1:0]   o = 2'($urandom_range(0, 3));
            load_a(a);
            if ($urandom_range(0, 3) != 0) load_b(b);
            start_exec(o); step(1);
            if (o == 2'b10) begin
                m_busy = 1'b1; m_valid = 1'b0; m_err = 1'b0;
                checks++;
                if (obs !== m_outs()) begin
                    errors++; $display("FAIL rand%0d_mul_busy: got %h want %h", n, obs, m_outs());
                end
                step(W);
            end
            model_exec(int'(o));
            checks++;
            if (obs !== m_outs()) begin
                errors++;
                $display("FAIL rand%0d_op%0d a=%0d b=%0d: got %h want %h",
                         n, o, m_a, m_b, obs, m_outs());
            end
            finish_exec();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_glitch_and_hold();
        test_reserved();
        test_simultaneous();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
